// File: rtl/phase_sequencer_if.sv
// Phase register write bus: one slot address plus its current-level and polarity bits.
interface phase_sequencer_if;
    logic [4:0] addr_bus;
    logic       I0_bus;
    logic       I1_bus;
    logic       Phase_bus;
    logic       busy;

    modport master (output addr_bus, I0_bus, I1_bus, Phase_bus, busy);
    modport slave  (input  addr_bus, I0_bus, I1_bus, Phase_bus, busy);
endinterface

// File: rtl/phase_sequencer.sv
// Per-motor microstep position tracking and round-robin scheduling of
// winding A/B current/polarity writes onto the shared phase register bus.
module phase_sequencer #(
    parameter int unsigned NUM_MOTORS = 4,
    parameter int unsigned PHASE_BASE = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_MOTORS-1:0] step_in,
    input  logic [NUM_MOTORS-1:0] dir_in,
    input  logic [NUM_MOTORS-1:0] enable_in,
    input  logic [1:0]            step_mode,
    input  logic                  overrun_clr,
    phase_sequencer_if.master     bus,
    output logic [NUM_MOTORS-1:0] overrun
);
    localparam int unsigned         NUM_SLOTS = 2 * NUM_MOTORS;
    localparam logic [4:0]          IDLE_ADDR = 5'd31;
    localparam logic [4:0]          LAST_SLOT = 5'(NUM_SLOTS - 1);
    localparam logic [NUM_SLOTS-1:0] SLOT0    = NUM_SLOTS'(1);

    logic [3:0]            pos [NUM_MOTORS];
    logic [NUM_MOTORS-1:0] step_prev;
    logic [NUM_MOTORS-1:0] en_prev;
    logic [1:0]            mode_prev;
    logic [NUM_SLOTS-1:0]  pending;
    logic [4:0]            last_grant;

    logic [NUM_MOTORS-1:0] step_edge;
    logic [NUM_MOTORS-1:0] en_change;
    logic                  mode_change;
    logic [NUM_MOTORS-1:0] overrun_set;
    logic [3:0]            increment;
    logic [NUM_SLOTS-1:0]  pending_set;
    logic [NUM_SLOTS-1:0]  pending_next;
    logic [NUM_SLOTS-1:0]  grant_mask;
    logic                  grant_valid;
    logic [4:0]            grant_slot;
    logic [2:0]            grant_data;

    // Returns {I1, I0, Phase}; winding B is the A table shifted back by 4 steps.
    function automatic logic [2:0] slot_code(input logic [3:0] k, input logic winding_b,
                                             input logic en);
        logic [3:0] idx;
        logic [2:0] d;
        logic [1:0] lvl;
        idx = winding_b ? k - 4'd4 : k;
        d   = (idx[2:0] <= 3'd4) ? idx[2:0] : 3'd0 - idx[2:0];
        case (d)
            3'd0, 3'd1: lvl = 2'b00;
            3'd2:       lvl = 2'b01;
            3'd3:       lvl = 2'b10;
            default:    lvl = 2'b11;
        endcase
        if (!en) lvl = 2'b11;
        return {lvl, ~(idx[3] ^ idx[2])};
    endfunction

    always_comb begin
        step_edge   = step_in & ~step_prev;
        en_change   = enable_in ^ en_prev;
        mode_change = (step_mode != mode_prev);
        pending_set = '0;
        overrun_set = '0;
        case (step_mode)
            2'b00:   increment = 4'd4;
            2'b01:   increment = 4'd2;
            default: increment = 4'd1;
        endcase
        for (int unsigned m = 0; m < NUM_MOTORS; m++) begin
            pending_set[2*m +: 2] = {2{step_edge[m] | en_change[m] | mode_change}};
            overrun_set[m]        = step_edge[m] & (|pending[2*m +: 2]);
        end
    end

    // Upward search from the slot after the last grant, wrapping at NUM_SLOTS.
    always_comb begin
        logic [5:0] cand;
        cand        = '0;
        grant_valid = 1'b0;
        grant_slot  = '0;
        grant_mask  = '0;
        grant_data  = '0;
        for (int unsigned i = 1; i <= NUM_SLOTS; i++) begin
            cand = {1'b0, last_grant} + 6'(i);
            if (cand >= 6'(NUM_SLOTS)) cand = cand - 6'(NUM_SLOTS);
            if (!grant_valid && (|(pending & (SLOT0 << cand)))) begin
                grant_valid = 1'b1;
                grant_slot  = cand[4:0];
            end
        end
        if (grant_valid) grant_mask = SLOT0 << grant_slot;
        for (int unsigned m = 0; m < NUM_MOTORS; m++) begin
            if (grant_valid && grant_slot[4:1] == 4'(m))
                grant_data = slot_code(pos[m], grant_slot[0], enable_in[m]);
        end
        // A set landing on the slot being granted keeps it pending for a rewrite.
        pending_next = (pending & ~grant_mask) | pending_set;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int unsigned m = 0; m < NUM_MOTORS; m++) pos[m] <= '0;
            step_prev     <= '0;
            en_prev       <= '0;
            mode_prev     <= step_mode;
            pending       <= '1;
            last_grant    <= LAST_SLOT;
            overrun       <= '0;
            bus.addr_bus  <= IDLE_ADDR;
            bus.I1_bus    <= 1'b0;
            bus.I0_bus    <= 1'b0;
            bus.Phase_bus <= 1'b0;
            bus.busy      <= 1'b0;
        end else begin
            for (int unsigned m = 0; m < NUM_MOTORS; m++) begin
                if (step_edge[m])
                    pos[m] <= dir_in[m] ? pos[m] + increment : pos[m] - increment;
            end
            step_prev <= step_in;
            en_prev   <= enable_in;
            mode_prev <= step_mode;
            pending   <= pending_next;
            overrun   <= (overrun & ~{NUM_MOTORS{overrun_clr}}) | overrun_set;
            bus.busy  <= grant_valid | (|pending_next);
            if (grant_valid) begin
                last_grant    <= grant_slot;
                bus.addr_bus  <= 5'(PHASE_BASE) + grant_slot;
                {bus.I1_bus, bus.I0_bus, bus.Phase_bus} <= grant_data;
            end else begin
                bus.addr_bus  <= IDLE_ADDR;
                bus.I1_bus    <= 1'b0;
                bus.I0_bus    <= 1'b0;
                bus.Phase_bus <= 1'b0;
            end
        end
    end
endmodule

// File: doc/phase_sequencer.md
# phase_sequencer

Microstep sequencer and bus scheduler for the motor phase registers. It tracks one electrical position per motor from step/direction inputs and translates each position into current-level (I1/I0) and polarity (Phase) codes for the motor's A and B windings. It then writes those codes to the phase registers over the shared addr/I0/I1/Phase bus, one write per clock, arbitrated round-robin. It sits between the motion front end (step/dir generators) and the bank of phase registers.

## Interface
- NUM_MOTORS, 4, number of motors, 1..15; each motor owns two phase slots.
- PHASE_BASE, 0, bus address of slot 0; must satisfy PHASE_BASE + 2*NUM_MOTORS - 1 < 31.
- clk  in  1  single clock for all logic.
- reset  in  1  synchronous, active-low reset (low = reset, sampled on rising clk).
- step_in  in  NUM_MOTORS  per-motor step request; rising edge = one step; already synchronous to clk.
- dir_in  in  NUM_MOTORS  per-motor direction; 1 = increment position, 0 = decrement; sampled on the step edge.
- enable_in  in  NUM_MOTORS  per-motor drive enable; 0 forces both windings to code 11 (off).
- step_mode  in  2  global increment: 00 = full (4), 01 = half (2), 10 and 11 = quarter (1).
- overrun_clr  in  1  clears all overrun flags.
- addr_bus  out  5  phase register address; 31 = idle, which matches no slot.
- I0_bus, I1_bus, Phase_bus  out  1 each  write data for the addressed slot.
- busy  out  1  high while any slot is pending or a write is on the bus.
- overrun  out  NUM_MOTORS  sticky; a step arrived while that motor still had a pending write.

## Operation
- Position: pos[m] is 4 bits, electrical angle pos*22.5°, wraps modulo 16 in both directions.
  - On a step edge, pos[m] is updated to pos[m] ± increment (per dir_in and step_mode), mod 16.
  - Step edge detect: step_in high now and low on the previous clk.
- Slots: s = 2m + p, with p = 0 for winding A and p = 1 for winding B. The slot address is PHASE_BASE + s.
- Winding A table for index k:
  - d = k mod 8 if (k mod 8) ≤ 4, else 8 − (k mod 8).
  - {I1,I0} by d: 0 → 00 (100%), 1 → 00, 2 → 01 (67%), 3 → 10 (33%), 4 → 11 (off).
  - Phase = 1 for k in 0..3 and 12..15; Phase = 0 for k in 4..11.
- Winding B: the A table evaluated at (k − 4) mod 16. As a result, B has Phase = 1 for k in 0..7.
- Enable:
  - When enable_in[m] = 0, both slots of motor m drive {I1,I0} = 11 with the Phase value from the table.
  - pos[m] still tracks steps while disabled.
- Pending bits, one per slot. Each of the following sets both of motor m's pending bits:
  - a step edge on m;
  - any change of enable_in[m];
  - any change of step_mode (sets all slots).
- Arbiter:
  - Each cycle it grants the first pending slot, searching upward from (last granted + 1) and wrapping past 2*NUM_MOTORS − 1.
  - Grant: register addr_bus, I1/I0/Phase for that slot (computed from the current pos and enable), and clear its pending bit.
  - No pending slot: addr_bus = 31, data = 0.
- Simultaneous set and clear on the same slot: set wins, so the slot is rewritten later with the new position.
- Overrun:
  - overrun[m] is set when a step edge arrives on m while either of m's pending bits is already set.
  - overrun_clr clears all flags. If a clear and a set happen in the same cycle, the set wins.
- Reset (low):
  - pos = 0 and enable history = 0 for every motor.
  - All pending bits = 1, so every slot is flushed after reset.
  - Last-granted pointer = 2*NUM_MOTORS − 1, so slot 0 is written first.
  - overrun = 0, addr_bus = 31, I0_bus = I1_bus = Phase_bus = 0.
  - busy is low during reset and goes high on the first cycle after release.
  - Reset asserted mid-write aborts the write: the bus reads idle on the next edge.

## Timing
- All outputs are registered and each drives the bus for exactly one clock. The phase register latches the data on the following edge.
- A step edge detected at edge E0 updates pos and pending at E0. If the arbiter is free, the slot appears on the bus after edge E1 and is latched at E2.
- Back-to-back grants are allowed, so the bus can carry a new slot every cycle.
- Worst-case wait for a pending slot is 2*NUM_MOTORS − 1 cycles.
- A post-reset flush takes 2*NUM_MOTORS cycles.
- Steps faster than the write rate: every step is counted in pos, but intermediate positions may never be written; overrun flags this.

## Test plan
- Reset flush:
  - Stimulus: release reset with all enables = 1, NUM_MOTORS = 4.
  - Response: addresses 0..7 appear on cycles 1..8. Even addresses carry {I1,I0} = 00, Phase = 1; odd addresses carry 11, Phase = 1. Then addr_bus = 31 and busy falls.
- Quarter step forward:
  - Stimulus: one step on motor 1, dir = 1, mode = 10.
  - Response: addr 2 with 00/Phase 1, then addr 3 with 10/Phase 1.
- Half step reverse from position 0:
  - Stimulus: one step on motor 0, dir = 0, mode = 01.
  - Response: pos = 14; addr 0 with 01/Phase 1; addr 1 with 01/Phase 0.
- Overrun and set-wins:
  - Stimulus: two steps on motor 2 two cycles apart while all 8 slots are pending.
  - Response: overrun[2] = 1; the final writes to addrs 4 and 5 reflect pos = 2.
  - Then assert overrun_clr: overrun returns to 0.
- Disable and fairness:
  - Stimulus: drop enable_in[3] while motors 0..2 step continuously.
  - Response: addrs 6 and 7 are written with 11 within 8 cycles, and round-robin order is kept.
- Reset mid-write:
  - Stimulus: assert reset while addr_bus = 5.
  - Response: next edge gives addr_bus = 31 with all data 0; after release, the flush restarts at slot 0.
